// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit with architectural HI/LO.
// Performs multi-cycle mult/multu/div/divu, mthi/mtlo writes and mfhi/mflo reads.
// Optional feature macro: MDU_MADD_EN enables madd (sel 6) and maddu (sel 7).
module e_mdu #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        move_to,
  input  logic        move_from,
  input  logic [2:0]  sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        dz_q, dz_d;

  logic signed [31:0] a_s, b_s;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [63:0]        divs_res, divu_res;
  logic [63:0]        res;
  logic               res_ok, res_div, res_dz;
  logic               unused_move_from;

  // Signed divide returning {remainder, quotient}; the overflow case
  // (most-negative / -1) and divide-by-zero are steered to divisor 1 so
  // the operator never sees an undefined input.
  function automatic logic [63:0] f_div_s(input logic signed [31:0] n,
                                          input logic signed [31:0] d);
    logic signed [31:0] dd, q, r;
    if (d == 32'sd0 || (n == 32'sh8000_0000 && d == -32'sd1)) dd = 32'sd1;
    else dd = d;
    q = n / dd;
    r = n % dd;
    return {r, q};
  endfunction

  // Unsigned divide returning {remainder, quotient}; zero divisor is masked.
  function automatic logic [63:0] f_div_u(input logic [31:0] n,
                                          input logic [31:0] d);
    logic [31:0] dd;
    dd = (d == 32'd0) ? 32'd1 : d;
    return {n % dd, n / dd};
  endfunction

  assign unused_move_from = move_from;
  assign a_s = $signed(a);
  assign b_s = $signed(b);

  // Operand arithmetic: products, quotients and the selected pending result.
  always_comb begin
    prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u   = {32'd0, a} * {32'd0, b};
    divs_res = f_div_s(a_s, b_s);
    divu_res = f_div_u(a, b);
    res      = 64'd0;
    res_ok   = 1'b0;
    res_div  = 1'b0;
    res_dz   = (b == 32'd0);
    case (sel)
      3'd0: begin res = prod_s;   res_ok = 1'b1; end
      3'd1: begin res = prod_u;   res_ok = 1'b1; end
      3'd2: begin res = divs_res; res_ok = 1'b1; res_div = 1'b1; end
      3'd3: begin res = divu_res; res_ok = 1'b1; res_div = 1'b1; end
`ifdef MDU_MADD_EN
      3'd6: begin res = {hi_q, lo_q} + prod_s; res_ok = 1'b1; end
      3'd7: begin res = {hi_q, lo_q} + prod_u; res_ok = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Next-state: launch, count down, commit, and HI/LO moves.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (res_ok) begin
            p_hi_d  = res[63:32];
            p_lo_d  = res[31:0];
            dz_d    = res_div && res_dz;
            cnt_d   = res_div ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);
            state_d = RUN;
          end
        end else if (move_to) begin
          if (sel == 3'd4) hi_d = a;
          if (sel == 3'd5) lo_d = a;
        end
      end
      RUN: begin
        if (cnt_q == 4'd1) begin
          if (!dz_q) begin
            hi_d = p_hi_q;
            lo_d = p_lo_q;
          end
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and architectural registers; reset clears everything including pending results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      p_hi_q  <= 32'd0;
      p_lo_q  <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign rd_data = (sel == 3'd5) ? lo_q : hi_q;

endmodule
